// File: rtl/chunked_add_pkg.sv
// Shared definitions for the chunked add/subtract sequencer: FSM state encoding
// and width helpers used by the top level.
package chunked_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int total_width(input int chunk_w, input int num_chunks);
    return chunk_w * num_chunks;
  endfunction

  function automatic int idx_width(input int num_chunks);
    return (num_chunks > 1) ? $clog2(num_chunks) : 1;
  endfunction

endpackage

// File: rtl/chunked_add_cla_slice.sv
// Combinational carry-lookahead adder slice with carry-in; generate = a&b,
// propagate = a|b, carries chained LSB to MSB.
module cla_slice #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);

  logic [WIDTH-1:0] w_g;
  logic [WIDTH-1:0] w_p;

  assign w_g = i_a & i_b;
  assign w_p = i_a | i_b;

  always_comb begin
    logic w_c;
    // NOTE: blocking assignments here so w_c carries each bit's result into the next iteration.
    w_c   = i_cin;
    o_sum = '0;
    for (int i = 0; i < WIDTH; i++) begin
      o_sum[i] = i_a[i] ^ i_b[i] ^ w_c;
      w_c      = w_g[i] | (w_p[i] & w_c);
    end
    o_cout = w_c;
  end

endmodule

// File: rtl/chunked_add_sequencer.sv
// Multi-cycle TOTAL_W-bit add/subtract: one CHUNK_W-bit lookahead slice reused
// LSB chunk first, carry held in a register between chunks.
module chunked_add_sequencer
  import chunked_add_pkg::*;
#(
  parameter  int CHUNK_W    = 8,
  parameter  int NUM_CHUNKS = 4,
  localparam int TOTAL_W    = total_width(CHUNK_W, NUM_CHUNKS)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [TOTAL_W-1:0] i_add1,
  input  logic [TOTAL_W-1:0] i_add2,
  input  logic               i_sub,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [TOTAL_W:0]   o_result,
  output logic               o_busy
);

  localparam int               IDX_W    = idx_width(NUM_CHUNKS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

  state_e             r_state;
  state_e             w_next_state;
  logic [IDX_W-1:0]   r_idx;
  logic               r_carry;
  logic [TOTAL_W-1:0] r_a;
  logic [TOTAL_W-1:0] r_b;
  logic [TOTAL_W:0]   r_result;

  logic               w_accept;
  logic               w_last;
  logic [CHUNK_W-1:0] w_a_chunk;
  logic [CHUNK_W-1:0] w_b_chunk;
  logic [CHUNK_W-1:0] w_sum;
  logic               w_cout;

  assign w_accept  = (r_state == IDLE) && i_valid;
  assign w_last    = (r_idx == LAST_IDX);
  assign w_a_chunk = r_a[r_idx*CHUNK_W +: CHUNK_W];
  assign w_b_chunk = r_b[r_idx*CHUNK_W +: CHUNK_W];
  assign o_result  = r_result;

  cla_slice #(.WIDTH(CHUNK_W)) u_slice (
    .i_a    (w_a_chunk),
    .i_b    (w_b_chunk),
    .i_cin  (r_carry),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next_state;
  end

  // Handshake outputs depend on state only, never on i_valid/i_ready.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    w_next_state = r_state;
    o_ready      = 1'b0;
    o_valid      = 1'b0;
    o_busy       = 1'b0;
    case (r_state)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid) w_next_state = RUN;
      end
      RUN: begin
        o_busy = 1'b1;
        if (w_last) w_next_state = DONE;
      end
      DONE: begin
        o_busy  = 1'b1;
        o_valid = 1'b1;
        if (i_ready) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      // NOTE: operand and result registers are plain flops, so they are reset like any other state.
      r_idx    <= '0;
      r_carry  <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_a     <= i_add1;
      r_b     <= i_add2 ^ {TOTAL_W{i_sub}};
      r_carry <= i_sub;
      r_idx   <= '0;
    end else if (r_state == RUN) begin
      r_result[r_idx*CHUNK_W +: CHUNK_W] <= w_sum;
      r_carry                            <= w_cout;
      if (w_last) r_result[TOTAL_W] <= w_cout;
      else        r_idx             <= r_idx + 1'b1;
    end
  end

endmodule

// File: tb/tb_chunked_add_sequencer.sv
// Self-checking bench: three sequencer configurations (8x4, 8x1, 1x5), directed
// steps on the 8x4 instance, then random traffic on all, checked via scoreboards.
module tb_chunked_add_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 8x4 instance
  logic        v0, rdy0, sub0, o_ready0, o_valid0, o_busy0;
  logic [31:0] a0, b0;
  logic [32:0] res0;
  // 8x1 instance
  logic        v1, rdy1, sub1, o_ready1, o_valid1, o_busy1;
  logic [7:0]  a1, b1;
  logic [8:0]  res1;
  // 1x5 instance
  logic        v2, rdy2, sub2, o_ready2, o_valid2, o_busy2;
  logic [4:0]  a2, b2;
  logic [5:0]  res2;

  chunked_add_sequencer #(.CHUNK_W(8), .NUM_CHUNKS(4)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(v0), .o_ready(o_ready0),
    .i_add1(a0), .i_add2(b0), .i_sub(sub0), .o_valid(o_valid0),
    .i_ready(rdy0), .o_result(res0), .o_busy(o_busy0)
  );
  chunked_add_sequencer #(.CHUNK_W(8), .NUM_CHUNKS(1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(v1), .o_ready(o_ready1),
    .i_add1(a1), .i_add2(b1), .i_sub(sub1), .o_valid(o_valid1),
    .i_ready(rdy1), .o_result(res1), .o_busy(o_busy1)
  );
  chunked_add_sequencer #(.CHUNK_W(1), .NUM_CHUNKS(5)) u_dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(v2), .o_ready(o_ready2),
    .i_add1(a2), .i_add2(b2), .i_sub(sub2), .o_valid(o_valid2),
    .i_ready(rdy2), .o_result(res2), .o_busy(o_busy2)
  );

  int n_vec = 0;
  int n_err = 0;
  int n_done0 = 0;
  int n_done1 = 0;
  int n_done2 = 0;
  logic [32:0] q0[$];
  logic [8:0]  q1[$];
  logic [5:0]  q2[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboards: handshakes are observed on the falling edge, ahead of the
  // rising edge that commits them; expectations come from plain arithmetic.
  always @(negedge clk) begin
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      q2.delete();
    end else begin
      if (v0 && o_ready0)
        q0.push_back(sub0 ? ({1'b0, a0} + {1'b0, ~b0} + 33'd1) : ({1'b0, a0} + {1'b0, b0}));
      if (v1 && o_ready1)
        q1.push_back(sub1 ? ({1'b0, a1} + {1'b0, ~b1} + 9'd1) : ({1'b0, a1} + {1'b0, b1}));
      if (v2 && o_ready2)
        q2.push_back(sub2 ? ({1'b0, a2} + {1'b0, ~b2} + 6'd1) : ({1'b0, a2} + {1'b0, b2}));
      if (o_valid0 && rdy0) begin
        if (q0.size() == 0) begin
          n_vec++; n_err++;
          $error("FAIL dut0_unexpected_output: observed %0h expected none", res0);
        end else begin
          check("dut0_result", 64'(res0), 64'(q0.pop_front()));
          n_done0++;
        end
      end
      if (o_valid1 && rdy1) begin
        if (q1.size() == 0) begin
          n_vec++; n_err++;
          $error("FAIL dut1_unexpected_output: observed %0h expected none", res1);
        end else begin
          check("dut1_result", 64'(res1), 64'(q1.pop_front()));
          n_done1++;
        end
      end
      if (o_valid2 && rdy2) begin
        if (q2.size() == 0) begin
          n_vec++; n_err++;
          $error("FAIL dut2_unexpected_output: observed %0h expected none", res2);
        end else begin
          check("dut2_result", 64'(res2), 64'(q2.pop_front()));
          n_done2++;
        end
      end
    end
  end

  // One directed operation on the 8x4 instance, holding i_ready low for `hold` cycles in DONE.
  task automatic op0(input logic [31:0] a, input logic [31:0] b, input logic s,
                     input int hold, input logic [32:0] exp);
    int lat;
    v0 = 1'b1; a0 = a; b0 = b; sub0 = s; rdy0 = 1'b0;
    tick();
    v0 = 1'b0; a0 = ~a; b0 = $urandom; sub0 = ~s;
    check("run_ready_low", 64'(o_ready0), 64'd0);
    check("run_busy", 64'(o_busy0), 64'd1);
    lat = 0;
    while (!o_valid0 && lat < 20) begin
      tick();
      lat++;
    end
    check("latency", 64'(lat), 64'd4);
    repeat (hold) begin
      check("bp_valid", 64'(o_valid0), 64'd1);
      check("bp_ready", 64'(o_ready0), 64'd0);
      check("bp_result", 64'(res0), 64'(exp));
      tick();
    end
    check("done_result", 64'(res0), 64'(exp));
    rdy0 = 1'b1;
    tick();
    check("post_valid", 64'(o_valid0), 64'd0);
    check("post_ready", 64'(o_ready0), 64'd1);
    check("post_busy", 64'(o_busy0), 64'd0);
    check("post_hold_result", 64'(res0), 64'(exp));
  endtask

  initial begin
    int last;
    int budget;
    int start;
    rst_n = 1'b0;
    v0 = 1'b0; rdy0 = 1'b0; sub0 = 1'b0; a0 = '0; b0 = '0;
    v1 = 1'b0; rdy1 = 1'b1; sub1 = 1'b0; a1 = '0; b1 = '0;
    v2 = 1'b0; rdy2 = 1'b1; sub2 = 1'b0; a2 = '0; b2 = '0;
    #12;
    check("rst_ready", 64'(o_ready0), 64'd1);
    check("rst_valid", 64'(o_valid0), 64'd0);
    check("rst_busy", 64'(o_busy0), 64'd0);
    check("rst_result", 64'(res0), 64'd0);
    check("rst_ready1", 64'(o_ready1), 64'd1);
    check("rst_ready2", 64'(o_ready2), 64'd1);
    tick();
    rst_n = 1'b1;
    tick();
    check("idle_ready", 64'(o_ready0), 64'd1);

    op0(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0, 33'h1_0000_0000);
    op0(32'h0000_0005, 32'h0000_0007, 1'b1, 0, 33'h0_FFFF_FFFE);
    op0(32'h0000_0007, 32'h0000_0005, 1'b1, 5, 33'h1_0000_0002);

    // Streaming: i_valid held, operands changing every cycle.
    rdy0 = 1'b1; v0 = 1'b1; last = -1;
    for (int i = 0; i < 30; i++) begin
      a0 = $urandom; b0 = $urandom; sub0 = 1'($urandom);
      if (o_ready0) begin
        if (last >= 0) check("stream_gap", 64'(i - last), 64'd6);
        last = i;
      end
      tick();
    end
    v0 = 1'b0;
    repeat (8) tick();
    check("stream_drained", 64'(q0.size()), 64'd0);

    // Reset while chunk 2 is in flight.
    a0 = 32'h1234_5678; b0 = 32'h0101_0101; sub0 = 1'b0; v0 = 1'b1;
    tick();
    v0 = 1'b0;
    tick();
    tick();
    check("mid_busy", 64'(o_busy0), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_result", 64'(res0), 64'd0);
    check("mid_rst_ready", 64'(o_ready0), 64'd1);
    check("mid_rst_valid", 64'(o_valid0), 64'd0);
    check("mid_rst_busy", 64'(o_busy0), 64'd0);
    tick();
    rst_n = 1'b1;
    repeat (8) begin
      check("aborted_no_valid", 64'(o_valid0), 64'd0);
      tick();
    end

    // Single-chunk configuration: one RUN cycle.
    v1 = 1'b1; a1 = 8'hFF; b1 = 8'h01; sub1 = 1'b0; rdy1 = 1'b0;
    tick();
    v1 = 1'b0;
    check("nc1_run_valid", 64'(o_valid1), 64'd0);
    check("nc1_run_busy", 64'(o_busy1), 64'd1);
    tick();
    check("nc1_valid", 64'(o_valid1), 64'd1);
    check("nc1_result", 64'(res1), 64'h100);
    rdy1 = 1'b1;
    tick();
    check("nc1_ready", 64'(o_ready1), 64'd1);

    // Random traffic on all three configurations.
    start = n_done0;
    budget = 0;
    while (n_done0 < start + 1000 && budget < 40000) begin
      v0 = ($urandom_range(3, 0) != 0); rdy0 = 1'($urandom);
      a0 = $urandom; b0 = $urandom; sub0 = 1'($urandom);
      v1 = ($urandom_range(3, 0) != 0); rdy1 = 1'($urandom);
      a1 = 8'($urandom); b1 = 8'($urandom); sub1 = 1'($urandom);
      v2 = ($urandom_range(3, 0) != 0); rdy2 = 1'($urandom);
      a2 = 5'($urandom); b2 = 5'($urandom); sub2 = 1'($urandom);
      tick();
      budget++;
    end
    check("rand_ops_reached", 64'(n_done0 >= start + 1000), 64'd1);
    check("rand_dut1_active", 64'(n_done1 > 1000), 64'd1);
    check("rand_dut2_active", 64'(n_done2 > 500), 64'd1);

    v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
    rdy0 = 1'b1; rdy1 = 1'b1; rdy2 = 1'b1;
    budget = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && budget < 50) begin
      tick();
      budget++;
    end
    check("drain_empty", 64'(q0.size() + q1.size() + q2.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

endmodule
